uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares the single UART transmitter among NUM_REQ byte sources. It grants one requester at a time and latches that requester's byte. It then issues a one-cycle start to the transmitter and holds the byte stable until the transmitter reports idle again. It sits between the requesting client blocks and the transmitter's start/data/valid_tx ports, in the same 25 MHz clock domain.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rr_pick.sv | 32 +++
 rtl/uart_tx_arbiter.sv | 75 +++++++
 tb/tb_uart_tx_arbiter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and arbiter state encoding
package uart_pkg;

  localparam int BAUD_DIV      = 2604;
  localparam int HALF_BAUD_DIV = 1302;
  localparam int MAX_REQ       = 8;
  localparam int ID_W          = $clog2(MAX_REQ);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE
  } arb_state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// rtl/uart_rr_pick.sv - combinational round-robin winner search
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last,
  output logic [ID_W-1:0]    winner,
  output logic               any_req
);

  int   idx;
  logic found;

  // Search starts one past the previous winner so it ends up lowest priority.
  always_comb begin
    winner  = '0;
    any_req = |req;
    found   = 1'b0;
    idx     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(last) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx]) begin
        winner = ID_W'(idx);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharing of the UART transmitter
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ack,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_valid,
  output logic                 busy,
  output logic [ID_W-1:0]      grant_id
);

  localparam logic [NUM_REQ-1:0] ACK_ONE = NUM_REQ'(1);

  arb_state_t      state;
  logic [ID_W-1:0] last;
  logic [ID_W-1:0] winner;
  logic            any_req;

  uart_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req     (req),
    .last    (last),
    .winner  (winner),
    .any_req (any_req)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      req_ack  <= '0;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
      busy     <= 1'b0;
      grant_id <= '0;
      last     <= ID_W'(NUM_REQ - 1);
    end else begin
      req_ack  <= '0;
      tx_start <= 1'b0;
      case (state)
        IDLE: begin
          // tx_data is only ever loaded here, so it stays put for the whole frame.
          if (any_req && tx_valid) begin
            tx_data  <= req_data[int'(winner)*8 +: 8];
            req_ack  <= ACK_ONE << winner;
            last     <= winner;
            grant_id <= winner;
            busy     <= 1'b1;
            state    <= LAUNCH;
          end
        end
        LAUNCH: begin
          tx_start <= 1'b1;
          state    <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!tx_valid) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (tx_valid) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ack;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        busy;
  logic [2:0]  grant_id;

  logic        model_idle;
  logic        ext_block = 1'b0;
  int          cnt;

  int tests = 0;
  int fails = 0;
  int m_last = 3;
  int waited;

  always #20 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_data (req_data),
    .req_ack  (req_ack),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .busy     (busy),
    .grant_id (grant_id)
  );

  // Transmitter: goes busy the cycle after tx_start, idle again 20 cycles later.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      model_idle <= 1'b1;
      cnt        <= 0;
    end else if (tx_start) begin
      model_idle <= 1'b0;
      cnt        <= 20;
    end else if (cnt > 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) model_idle <= 1'b1;
    end
  end
  assign tx_valid = model_idle & ~ext_block;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Winner = active requester at the smallest rotational distance after the last winner.
  function automatic int ref_pick(input logic [3:0] r, input int last);
    int best = -1;
    int bestd = 99;
    for (int i = 0; i < 4; i++) begin
      if (r[i]) begin
        int d;
        d = (i - last - 1 + 8) % 4;
        if (d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
    return best;
  endfunction

  function automatic logic [7:0] byte_of(input int i);
    logic [31:0] v;
    v = req_data;
    return v[i*8 +: 8];
  endfunction

  task automatic run_frame(input int exp_w, output int lat);
    int n;
    logic [7:0] exp_b;
    exp_b = byte_of(exp_w);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (req_ack == 4'b0 && n < 60);
    lat = n;
    check("ack", {28'b0, req_ack}, 32'(4'b1 << exp_w));
    check("grant_id", {29'b0, grant_id}, 32'(exp_w));
    check("tx_data", {24'b0, tx_data}, {24'b0, exp_b});
    check("busy_on", {31'b0, busy}, 32'd1);
    check("start_early", {31'b0, tx_start}, 32'd0);
    m_last = exp_w;
    @(negedge clk);
    check("tx_start", {31'b0, tx_start}, 32'd1);
    check("ack_pulse", {28'b0, req_ack}, 32'd0);
    n = 0;
    while (busy && n < 60) begin
      @(negedge clk);
      n++;
      if (busy) check("tx_hold", {24'b0, tx_data}, {24'b0, exp_b});
    end
    check("busy_fall", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    @(negedge clk);
    check("rst_ack", {28'b0, req_ack}, 32'd0);
    check("rst_start", {31'b0, tx_start}, 32'd0);
    check("rst_data", {24'b0, tx_data}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_gid", {29'b0, grant_id}, 32'd0);
    reset = 1'b0;

    // Single requester
    req = 4'b0001; req_data = 32'h000000A5;
    run_frame(ref_pick(req, m_last), waited);

    // All requesters held high
    req = 4'b1111; req_data = 32'h43322110;
    for (int i = 0; i < 5; i++) run_frame(ref_pick(req, m_last), waited);

    // Two requesters alternate
    req = 4'b1010;
    for (int i = 0; i < 4; i++) run_frame(ref_pick(req, m_last), waited);

    // Requester 2 drops before its turn
    req = 4'b0111; req_data = 32'h44332211;
    run_frame(ref_pick(req, m_last), waited);
    req = 4'b0011;
    run_frame(ref_pick(req, m_last), waited);
    run_frame(ref_pick(req, m_last), waited);

    // Randomized requests and bytes
    for (int i = 0; i < 12; i++) begin
      req      = 4'($urandom_range(1, 15));
      req_data = $urandom;
      run_frame(ref_pick(req, m_last), waited);
    end

    // Reset during WAIT_DONE
    req = 4'b0100; req_data = 32'h00550000;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (tx_valid && waited < 60);
    check("reach_wait_done", {31'b0, tx_valid}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst_ack", {28'b0, req_ack}, 32'd0);
    check("mid_rst_start", {31'b0, tx_start}, 32'd0);
    check("mid_rst_data", {24'b0, tx_data}, 32'd0);
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_gid", {29'b0, grant_id}, 32'd0);
    @(negedge clk);
    check("mid_rst_hold_start", {31'b0, tx_start}, 32'd0);
    m_last = 3;
    req = 4'b1111; req_data = 32'h9988AA77;
    reset = 1'b0;
    run_frame(ref_pick(req, m_last), waited);

    // Transmitter busy for an external reason
    ext_block = 1'b1;
    req = 4'b0100; req_data = 32'h00C30000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("blocked_ack", {28'b0, req_ack}, 32'd0);
      check("blocked_busy", {31'b0, busy}, 32'd0);
    end
    ext_block = 1'b0;
    run_frame(ref_pick(req, m_last), waited);
    check("unblock_latency", 32'(waited), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
